instn_issue_ctrl: RTL
=====================

# instn_issue_ctrl

In-order issue controller for the RV32 R-type instruction decoder path. It buffers incoming 32-bit instructions in a small FIFO and splits the head entry into the standard R-type fields. It tracks in-flight destination registers in a 32-bit scoreboard and issues one instruction per cycle to the execute stage when no register hazard exists. It sits between instruction fetch and the ALU/register-file write-back.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- R_OPCODE, 7'b0110011, only opcode accepted for issue
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_instrn  in  32  instruction word
- in_ready  out  1  FIFO can accept; equals !full
- flush  in  1  discard all buffered instructions
- iss_valid  out  1  head entry is issuable
- iss_ready  in  1  execute stage accepts
- iss_op_code  out  7  head[6:0]
- iss_dest_reg  out  5  head[11:7]
- iss_fn3  out  3  head[14:12]
- iss_src_reg_1  out  5  head[19:15]
- iss_src_reg_2  out  5  head[24:20]
- iss_fn7  out  7  head[31:25]
- wb_valid  in  1  execute stage retires a result
- wb_rd  in  5  register being written back
- busy_regs  out  32  scoreboard; bit n set means xn is pending
- stall  out  1  head valid and legal but blocked by a hazard
- illegal  out  1  one-cycle pulse when a non-R-type head is dropped
- count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Push: when in_valid && in_ready, in_instrn is written at the write pointer and count increments.
- Head decode: combinational slicing of the FIFO head into the iss_* fields.
- Legality: the head is legal when head[6:0] == R_OPCODE. An illegal head is popped unconditionally in the cycle it is at the head; illegal pulses for that cycle, and no issue occurs.
- Hazard: busy_regs[rs1] | busy_regs[rs2] | busy_regs[rd], with x0 excluded from every check. The WAW check is included.
- iss_valid = !empty && legal && !hazard.
- stall = !empty && legal && hazard.
- Issue: when iss_valid && iss_ready, the head pops. If rd != 0, busy_regs[rd] is set at the same edge.
- Write-back: when wb_valid, busy_regs[wb_rd] is cleared. wb_rd == 0 is ignored.
  - The hazard check uses registered busy_regs, with no write-back bypass.
  - Set and clear cannot collide on the same register, because the WAW check blocks that issue.
- busy_regs[0] is always 0.
- Flush: at the next edge, the pointers and count go to 0 and any push or pop in that cycle is ignored. busy_regs is untouched, because issued instructions still retire.
- Pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- A simultaneous push and pop leaves count unchanged. Push is refused when full, even if a pop occurs in the same cycle.

## Timing
- Reset values (async, immediate on rst_n low): pointers 0, count 0, busy_regs 0, in_ready 1, iss_valid 0, stall 0, illegal 0. The iss_* fields are don't-care while iss_valid is 0.
- Latency: a word pushed at edge N into an empty FIFO with no hazard gives iss_valid high in the cycle after edge N.
- Issue-to-busy: busy_regs[rd] is set at the issue edge, so a dependent instruction at the new head sees stall in the very next cycle.
- Write-back-to-issue: a clear at edge M lets a stalled head assert iss_valid in the cycle after M.
- Throughput: one issue per cycle when there are no hazards and iss_ready is held high.
- Handshake: iss_valid may drop without a transfer only on flush or reset. The iss_* fields are stable while iss_valid && !iss_ready.
- Reset mid-operation: all state is cleared immediately, and in-flight scoreboard entries are lost by design.

## Test plan
- Reset: hold rst_n low with in_valid=1 -> in_ready=1, iss_valid=0, count=0, busy_regs=0. Release rst_n -> the first push is accepted at the next edge.
- Single issue: push 0x00028233 with iss_ready=1 -> next cycle iss_valid=1 with op_code=0110011, rd=4, rs1=5, rs2=0, fn3=000, fn7=0000000. After the issue edge, busy_regs=0x00000010.
- RAW stall: push 0x02030333 (rd=6, fn7=0000001) then 0x000303B3 (rd=7, rs1=6) -> the second head shows stall=1 and iss_valid=0. Assert wb_valid with wb_rd=6 -> the next cycle shows iss_valid=1 and rd=7.
- Full/wrap: with iss_ready=0, push 5 words -> in_ready=0 after the 4th, count=4, and the 5th is not accepted. Release iss_ready -> the 4 words issue in push order and the pointers wrap.
- Illegal/flush: push 0x00000013 -> illegal pulses one cycle, with no iss_valid and no busy change. Fill 3 words, then assert flush -> count=0 next cycle while busy_regs is unchanged.
- Async reset mid-run: drop rst_n while busy_regs=0x00000040 and count=2 -> everything returns to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/instn_issue_ctrl.sv
// In-order R-type issue controller: instruction FIFO, head field
// decode and a destination-register scoreboard for hazard blocking.
module instn_issue_ctrl #(
  parameter int         DEPTH    = 4,
  parameter logic [6:0] R_OPCODE = 7'b0110011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_instrn,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [6:0]               iss_op_code,
  output logic [4:0]               iss_dest_reg,
  output logic [2:0]               iss_fn3,
  output logic [4:0]               iss_src_reg_1,
  output logic [4:0]               iss_src_reg_2,
  output logic [6:0]               iss_fn7,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  output logic [31:0]              busy_regs,
  output logic                     stall,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   head;
  logic [31:0]   busy_nxt;
  logic          empty;
  logic          full;
  logic          legal;
  logic          hz_rs1;
  logic          hz_rs2;
  logic          hz_rd;
  logic          hazard;
  logic          push;
  logic          pop;
  logic          issue;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign head     = mem[rd_ptr];

  assign iss_op_code   = head[6:0];
  assign iss_dest_reg  = head[11:7];
  assign iss_fn3       = head[14:12];
  assign iss_src_reg_1 = head[19:15];
  assign iss_src_reg_2 = head[24:20];
  assign iss_fn7       = head[31:25];

  assign legal  = (head[6:0] == R_OPCODE);

  // x0 never creates a dependency
  assign hz_rs1 = (iss_src_reg_1 != 5'd0)
               && busy_regs[iss_src_reg_1];
  assign hz_rs2 = (iss_src_reg_2 != 5'd0)
               && busy_regs[iss_src_reg_2];
  assign hz_rd  = (iss_dest_reg != 5'd0)
               && busy_regs[iss_dest_reg];
  assign hazard = hz_rs1 || hz_rs2 || hz_rd;

  assign iss_valid = !empty && legal && !hazard;
  assign stall     = !empty && legal && hazard;
  assign illegal   = !empty && !legal;

  // flush overrides any transfer in the same cycle
  assign push  = in_valid && in_ready && !flush;
  assign issue = iss_valid && iss_ready && !flush;
  assign pop   = issue || (illegal && !flush);

  // Storage array; data words need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_instrn;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scoreboard update: clear on write-back, set on issue
  always_comb begin
    busy_nxt = busy_regs;
    if (wb_valid) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (issue) begin
      busy_nxt[iss_dest_reg] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; survives flush since issued ops still retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_regs <= '0;
    end else begin
      busy_regs <= busy_nxt;
    end
  end

endmodule
